// File: rtl/out_serializer.sv
// ============================================================================
// Module   : out_serializer
// Brief    : Parallel-in, serial-out transmitter (start, LSB-first data, stop)
//            with a ready flag and a sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic [WIDTH-1:0] DATA,
    input  logic             clr_ovr,
    output logic             tx,
    output logic             FGO,
    output logic             overrun
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cycle_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;

    logic cycle_wrap;
    assign cycle_wrap = (cycle_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            tx        <= 1'b1;
            FGO       <= 1'b1;
            overrun   <= 1'b0;
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
        end else begin
            // A busy write takes precedence over a simultaneous clear.
            if (write && !FGO) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    cycle_cnt <= '0;
                    bit_cnt   <= '0;
                    if (write) begin
                        shreg <= DATA;
                        tx    <= 1'b0;
                        FGO   <= 1'b0;
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (cycle_wrap) begin
                        cycle_cnt <= '0;
                        bit_cnt   <= '0;
                        tx        <= shreg[0];
                        shreg     <= shreg >> 1;
                        state     <= ST_DATA;
                    end else begin
                        cycle_cnt <= cycle_cnt + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (cycle_wrap) begin
                        cycle_cnt <= '0;
                        if (bit_cnt == BW'(WIDTH - 1)) begin
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                            state   <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + CW'(1);
                    end
                end

                ST_STOP: begin
                    if (cycle_wrap) begin
                        cycle_cnt <= '0;
                        tx        <= 1'b1;
                        FGO       <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        cycle_cnt <= cycle_cnt + CW'(1);
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    tx        <= 1'b1;
                    FGO       <= 1'b1;
                    cycle_cnt <= '0;
                    bit_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/out_serializer.md
OUT_SERIALIZER -- requirements
Module: out_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits.
REQ-002 Parameter: DIV, default 16, clock cycles per serial bit; legal range 2 to 65535.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 write  input  1  parallel-load strobe, one cycle per word.
REQ-006 DATA  input  WIDTH  word to transmit, sampled when write is accepted.
REQ-007 clr_ovr  input  1  clears the overrun flag.
REQ-008 tx  output  1  serial line, registered, idle high.
REQ-009 FGO  output  1  ready flag, registered; 1 = idle and able to accept a word.
REQ-010 overrun  output  1  sticky flag, registered; set when a write arrives while busy.

Function
REQ-011 The block SHALL implement states IDLE, START, DATA, STOP in a registered FSM.
REQ-012 In IDLE, write=1 SHALL be accepted: DATA latched into an internal WIDTH-bit shift register, next state START.
REQ-013 FGO SHALL be 1 only in IDLE; it SHALL go 0 on the edge that accepts a write.
REQ-014 tx SHALL go 0 on the edge that accepts a write (start bit visible one cycle after write asserted).
REQ-015 Each bit (start, every data bit, stop) SHALL hold tx stable for exactly DIV cycles, timed by a cycle counter of width clog2(DIV).
REQ-016 The cycle counter SHALL count 0..DIV-1, wrap to 0 at DIV-1 and advance bit/state only on the wrap cycle.
REQ-017 Data bits SHALL be sent LSB first, DATA[0] through DATA[WIDTH-1], with the shift register shifting right once per bit.
REQ-018 A bit counter SHALL count data bits 0..WIDTH-1; DATA leaves to STOP after bit WIDTH-1 completes.
REQ-019 STOP SHALL drive tx=1 for DIV cycles, then return to IDLE with FGO=1 on the following edge.
REQ-020 Total frame: tx low-to-FGO-high span SHALL be exactly (WIDTH+2)*DIV cycles.
REQ-021 A new write accepted on the first IDLE cycle after STOP SHALL start the next frame with no extra idle bit.
REQ-022 write while FGO=0 SHALL be ignored (latched word, tx, timing unaffected) and SHALL set overrun=1 on the next edge.
REQ-023 overrun SHALL remain 1 until clr_ovr=1 or reset; if clr_ovr and a busy write coincide, set wins.
REQ-024 Changes on DATA after acceptance SHALL not affect the frame in progress.

Reset
REQ-025 reset=1 SHALL, on the next rising edge, force state IDLE, tx=1, FGO=1, overrun=0, counters 0, shift register 0.
REQ-026 reset SHALL take priority over write and clr_ovr in the same cycle.
REQ-027 reset mid-frame SHALL abort the frame; no remaining bits are sent and tx returns high on that edge.

Verification (WIDTH=8, DIV=4)
REQ-028 Reset then idle 10 cycles -> tx=1, FGO=1, overrun=0 throughout.
REQ-029 write=1, DATA=8'hA5 in IDLE -> tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; FGO=0 for 40 cycles, then 1.
REQ-030 write DATA=8'h3C at cycle 10 of a frame -> frame bits unchanged, overrun=1 next cycle; clr_ovr pulse -> overrun=0.
REQ-031 Back-to-back: write 8'h01, then write 8'h80 on first FGO=1 cycle -> two contiguous 40-cycle frames, no idle gap.
REQ-032 reset asserted during data bit 3 -> next edge tx=1, FGO=1; subsequent write 8'hFF sends a complete clean frame.
REQ-033 reset and write asserted together in IDLE -> write ignored, tx=1, FGO=1.
